clk_div_sched: RTL and testbench

//  Controller for the shared power-of-two clock divider. Owns the free-running divide counter.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_sched_if.sv | 26 ++
 rtl/clk_div_counter.sv | 22 ++
 rtl/clk_div_sched.sv | 102 ++++++++++
 tb/tb_clk_div_sched.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the power-of-two clock divider: ratio selector codes and FSM states.
package clk_div_pkg;

    localparam int SEL_DIV1  = 0;
    localparam int SEL_DIV2  = 1;
    localparam int SEL_DIV4  = 2;
    localparam int SEL_DIV8  = 3;
    localparam int SEL_DIV16 = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/clk_div_sched_if.sv
// Config handshake and divider output bundle between the pin wrapper and the divider controller.
interface clk_div_sched_if #(
    parameter int CNT_W = 4,
    parameter int SEL_W = 3
);
    logic             ena;
    logic             cfg_valid;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_ready;
    logic             cfg_err;
    logic             busy;
    logic [SEL_W-1:0] cur_sel;
    logic             div_out;
    logic             div_tick;
    logic [CNT_W-1:0] taps;

    modport master (
        output ena, cfg_valid, cfg_sel,
        input  cfg_ready, cfg_err, busy, cur_sel, div_out, div_tick, taps
    );

    modport slave (
        input  ena, cfg_valid, cfg_sel,
        output cfg_ready, cfg_err, busy, cur_sel, div_out, div_tick, taps
    );
endinterface

// File: rtl/clk_div_counter.sv
// Free-running divide counter with run-enable hold; also exposes next value and wrap.
module clk_div_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             wrap_o
);
    logic [CNT_W-1:0] cnt_q;

    assign cnt_next_o = ena_i ? cnt_q + 1'b1 : cnt_q;
    assign wrap_o     = ena_i & (&cnt_q);
    assign cnt_o      = cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_next_o;
    end
endmodule

// File: rtl/clk_div_sched.sv
// Divider controller: accepts ratio requests and applies them only at counter wrap so the
// selected waveform never shows a runt or stretched period.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int SEL_W   = 3,
    parameter int RST_SEL = SEL_DIV2
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_sched_if.slave bus
);
    logic [CNT_W-1:0] cnt, cnt_next, mask;
    logic             wrap, xfer;
    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d, pend_sel_q, pend_sel_d;
    logic             err_q, err_d;
    logic             div_out_q, div_out_d, div_tick_q, div_tick_d;

    clk_div_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .ena_i     (bus.ena),
        .cnt_o     (cnt),
        .cnt_next_o(cnt_next),
        .wrap_o    (wrap)
    );

    assign xfer = bus.cfg_valid && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A request landing on the wrap edge waits a full period; it is never applied same-cycle.
                if (xfer) begin
                    if (int'(bus.cfg_sel) > CNT_W) begin
                        err_d = 1'b1;
                    end else if (bus.cfg_sel != cur_sel_q) begin
                        pend_sel_d = bus.cfg_sel;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                if (wrap) begin
                    cur_sel_d = pend_sel_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the post-edge counter and ratio, so the switch edge already ticks.
    always_comb begin
        mask       = '0;
        div_out_d  = 1'b0;
        div_tick_d = 1'b0;
        for (int i = 0; i < CNT_W; i++) mask[i] = (i < int'(cur_sel_d));
        if (bus.ena) begin
            if (cur_sel_d == '0) begin
                div_out_d  = 1'b1;
                div_tick_d = 1'b1;
            end else begin
                div_tick_d = ((cnt_next & mask) == '0);
                for (int i = 0; i < CNT_W; i++)
                    if (int'(cur_sel_d) == i + 1) div_out_d = cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_sel_q  <= SEL_W'(RST_SEL);
            pend_sel_q <= '0;
            err_q      <= 1'b0;
            div_out_q  <= 1'b0;
            div_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            err_q      <= err_d;
            div_out_q  <= div_out_d;
            div_tick_q <= div_tick_d;
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == PEND);
    assign bus.cfg_err   = err_q;
    assign bus.cur_sel   = cur_sel_q;
    assign bus.div_out   = div_out_q;
    assign bus.div_tick  = div_tick_q;
    assign bus.taps      = cnt;
endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: table of per-cycle vectors plus hand sequences for stall and reset.
module tb_clk_div_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    clk_div_sched_if #(.CNT_W(4), .SEL_W(3)) bus ();
    clk_div_sched #(.CNT_W(4), .SEL_W(3), .RST_SEL(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       ena, vld;
        logic [2:0] sel;
        logic [3:0] taps;
        logic       out, tick, rdy, busy;
        logic [2:0] cur;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, v, input logic [2:0] s, input logic [3:0] t,
                       input logic o, tk, r, b, input logic [2:0] c, input logic er);
        vec_t x;
        x.ena = e; x.vld = v; x.sel = s; x.taps = t; x.out = o; x.tick = tk;
        x.rdy = r; x.busy = b; x.cur = c; x.err = er;
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int t, o, tk, r, b, c, er);
        chk({nm, ".taps"}, int'(bus.taps), t);
        chk({nm, ".div_out"}, int'(bus.div_out), o);
        chk({nm, ".div_tick"}, int'(bus.div_tick), tk);
        chk({nm, ".cfg_ready"}, int'(bus.cfg_ready), r);
        chk({nm, ".busy"}, int'(bus.busy), b);
        chk({nm, ".cur_sel"}, int'(bus.cur_sel), c);
        chk({nm, ".cfg_err"}, int'(bus.cfg_err), er);
    endtask

    initial begin
        int n;
        //  ena vld sel taps out tick rdy busy cur err
        add(1, 0, 0,  1, 1, 0, 1, 0, 1, 0);
        add(1, 0, 0,  2, 0, 1, 1, 0, 1, 0);
        add(1, 0, 0,  3, 1, 0, 1, 0, 1, 0);
        add(1, 1, 3,  4, 0, 1, 0, 1, 1, 0);   // accepted at cnt=3
        add(1, 1, 2,  5, 1, 0, 0, 1, 1, 0);   // ignored while busy
        add(1, 0, 0,  6, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0,  7, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0,  8, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0,  9, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0, 10, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 11, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0, 12, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 13, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0, 14, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 15, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0,  0, 0, 1, 1, 0, 3, 0);   // switch to div8 at wrap
        add(1, 0, 0,  1, 0, 0, 1, 0, 3, 0);
        add(1, 0, 0,  2, 0, 0, 1, 0, 3, 0);
        add(1, 0, 0,  3, 0, 0, 1, 0, 3, 0);
        add(1, 0, 0,  4, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0,  5, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0,  6, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0,  7, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0,  8, 0, 1, 1, 0, 3, 0);
        add(1, 1, 5,  9, 0, 0, 1, 0, 3, 1);   // out-of-range sel
        add(1, 0, 0, 10, 0, 0, 1, 0, 3, 0);
        add(1, 1, 3, 11, 0, 0, 1, 0, 3, 0);   // same sel: no-op
        add(1, 0, 0, 12, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0, 13, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0, 14, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0, 15, 1, 0, 1, 0, 3, 0);
        add(1, 0, 0,  0, 0, 1, 1, 0, 3, 0);
        add(1, 0, 0,  1, 0, 0, 1, 0, 3, 0);

        bus.ena = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_sel = '0;
        #2 rst_n = 1'b0;
        step(); step();
        chk_all("reset", 0, 0, 0, 1, 0, 1, 0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.ena = tbl[i].ena; bus.cfg_valid = tbl[i].vld; bus.cfg_sel = tbl[i].sel;
            step();
            chk_all($sformatf("v%0d", i), int'(tbl[i].taps), int'(tbl[i].out), int'(tbl[i].tick),
                    int'(tbl[i].rdy), int'(tbl[i].busy), int'(tbl[i].cur), int'(tbl[i].err));
        end
        bus.cfg_valid = 1'b0;

        // Request presented exactly on the wrap edge waits a full period.
        for (int i = 0; i < 14; i++) step();
        chk("pre_wrap.taps", int'(bus.taps), 15);
        bus.cfg_valid = 1'b1; bus.cfg_sel = 3'd4;
        step();
        bus.cfg_valid = 1'b0;
        chk_all("wrap_req", 0, 0, 1, 0, 1, 3, 0);
        for (int i = 0; i < 5; i++) step();
        chk_all("pend5", 5, 1, 0, 0, 1, 3, 0);

        // Stall in PEND: everything frozen, outputs low.
        bus.ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all($sformatf("stall%0d", i), 5, 0, 0, 0, 1, 3, 0);
        end
        bus.ena = 1'b1;
        n = 0;
        while (bus.busy && n < 40) begin
            step();
            n++;
        end
        chk("resume_wait", n, 11);
        chk_all("div16_start", 0, 0, 1, 1, 0, 4, 0);
        for (int i = 0; i < 8; i++) step();
        chk_all("div16_half", 8, 1, 0, 1, 0, 4, 0);

        // Reset mid-PEND within a div16 period.
        bus.cfg_valid = 1'b1; bus.cfg_sel = 3'd2;
        step();
        bus.cfg_valid = 1'b0;
        chk_all("pend_b", 9, 1, 0, 0, 1, 4, 0);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 1, 0, 1, 0);
        step(); step();
        chk_all("in_rst", 0, 0, 0, 1, 0, 1, 0);
        #3 rst_n = 1'b1;
        step();
        chk_all("post_rst", 1, 1, 0, 1, 0, 1, 0);
        step();
        chk_all("post_rst2", 2, 0, 1, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
